crc_frame_source: RTL
=====================

// Module: crc_frame_source
// PURPOSE
//  Upstream framer for the CRC checker. Takes a frame length and payload bytes from the host.
//  Emits the length on the count channel, then the payload on the data channel, then one
//  CRC-8 trailer byte on the data channel.
//  The checker consumes count, COUNT payload words, then the trailer, and reports match.
// PARAMETERS
//  DATA_W    8      width of length, payload, CRC and trailer
//  POLY      8'h07  CRC generator polynomial (implicit x^DATA_W term)
//  CRC_INIT  8'h00  CRC register value at frame start
// PORTS
//  clk         in   1       sole clock, rising edge
//  rst_n       in   1       asynchronous active-low reset
//  len_valid   in   1       host offers frame length
//  len_ready   out  1       framer accepts length
//  len_data    in   DATA_W  payload byte count, 0..2^DATA_W-1
//  in_valid    in   1       host offers payload byte
//  in_ready    out  1       framer accepts payload byte
//  in_data     in   DATA_W  payload byte
//  cnt_valid   out  1       count channel valid (registered)
//  cnt_ready   in   1       checker accepts count
//  cnt_data    out  DATA_W  frame length (registered)
//  d_valid     out  1       data channel valid (registered)
//  d_ready     in   1       checker accepts data word
//  d_data      out  DATA_W  payload byte or CRC trailer (registered)
//  busy        out  1       high in states PAYLOAD and TRAILER
// BEHAVIOUR
//  - Handshakes: a transfer occurs when valid && ready are both high at a rising clk edge.
//  - Once asserted, valid and data hold stable until the transfer completes.
//  - Reset values:
//    - outputs: cnt_valid=0, d_valid=0, cnt_data=0, d_data=0, busy=0, len_ready=0, in_ready=0.
//    - internal: state=IDLE, remaining=0, crc=CRC_INIT.
//  - Count register: cnt_valid clears on cnt_ready handshake, independent of the FSM.
//  - Data register: one-entry. It may load when (!d_valid || d_ready), which is the "slot free" condition.
//  - FSM states: IDLE, PAYLOAD, TRAILER.
//  - IDLE: len_ready = !cnt_valid; in_ready = 0. On length accept:
//    - cnt_data<=len_data, cnt_valid<=1, remaining<=len_data, crc<=CRC_INIT.
//    - next state PAYLOAD if len_data != 0, else TRAILER.
//  - PAYLOAD: in_ready = slot free; len_ready = 0. On byte accept:
//    - d_data<=in_data, d_valid<=1, crc<=crc_next(crc,in_data), remaining<=remaining-1.
//    - when remaining==1 at accept, go to TRAILER.
//  - TRAILER: in_ready = 0. When slot free:
//    - d_data<=crc, d_valid<=1, go to IDLE.
//    - the crc used already includes the final payload byte.
//  - crc_next: MSB-first, no reflection, no final XOR. For each of DATA_W bits:
//    - fb = crc[MSB] ^ din[bit]; crc = (crc<<1) ^ (fb ? POLY : 0).
//  - Latency:
//    - length accept -> cnt_valid high next cycle.
//    - payload accept -> d_valid next cycle.
//    - trailer loads the cycle after the last payload byte leaves the slot, or with it if d_ready=1.
//    - full throughput with d_ready held high: one byte per cycle, trailer back-to-back.
//  - Zero-length frame: count 0, then trailer = CRC_INIT; no payload words.
//  - Next frame: a new length may be accepted in IDLE while the previous trailer still waits in d_data.
//    Per-channel ordering is preserved.
//  - Backpressure: the framer never drops or duplicates a word, and never overwrites d_data or cnt_data while valid && !ready.
//  - Reset mid-frame: all state clears asynchronously. The partial frame is discarded; the checker is reset with it.
//  - remaining is DATA_W bits; length 2^DATA_W-1 is legal and never wraps.
// TESTING
//  1. len=9, payload 31..39 hex, ready high -> cnt_data=09; d: 31..39 then F4; busy low after trailer.
//  2. len=0 -> cnt_data=00, single d word 00, no payload accepted (in_ready stays 0).
//  3. len=1, byte FF, d_ready low 5 cycles -> d_data holds FF; in_ready 0; trailer F3 after release.
//  4. Two back-to-back frames (len=1 byte 01 -> trailer 07; len=1 byte 00 -> trailer 00), cnt_ready stalled 3 cycles
//     -> second len_ready waits for first count transfer; streams in order.
//  5. rst_n low mid-PAYLOAD (after 2 of 4 bytes) -> outputs zero immediately; next len=1 byte 01 -> trailer 07.
//  6. Random valid/ready toggling, 200 frames, len 0..255 -> scoreboard matches reference CRC model, no loss.

Source files
------------

// File: rtl/crc_frame_source.sv
// crc_frame_source: upstream framer for the CRC checker.
// For each frame it sends the length on the count channel, then the payload
// bytes on the data channel, then one CRC trailer byte on the data channel.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | waiting for a frame length (only while count slot is empty)
// S_PAYLOAD | forwarding payload bytes, folding each into the CRC
// S_TRAILER | waiting for a free data slot to emit the CRC trailer
module crc_frame_source #(
  parameter int unsigned           DATA_W   = 8,
  parameter logic [DATA_W-1:0]     POLY     = 8'h07,
  parameter logic [DATA_W-1:0]     CRC_INIT = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              len_valid,
  output logic              len_ready,
  input  logic [DATA_W-1:0] len_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              cnt_valid,
  input  logic              cnt_ready,
  output logic [DATA_W-1:0] cnt_data,
  output logic              d_valid,
  input  logic              d_ready,
  output logic [DATA_W-1:0] d_data,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PAYLOAD = 2'd1,
    S_TRAILER = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_started;
  logic              r_cnt_valid;
  logic [DATA_W-1:0] r_cnt_data;
  logic              r_d_valid;
  logic [DATA_W-1:0] r_d_data;
  logic [DATA_W-1:0] r_remaining;
  logic [DATA_W-1:0] r_crc;

  logic              w_slot_free;
  logic              w_len_acc;
  logic              w_in_acc;
  logic              w_trl_load;

  // MSB-first CRC update over one data word, no reflection, no final XOR.
  function automatic logic [DATA_W-1:0] crc_next(input logic [DATA_W-1:0] crc,
                                                 input logic [DATA_W-1:0] din);
    logic [DATA_W-1:0] c;
    logic              fb;
    c = crc;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      fb = c[DATA_W-1] ^ din[i];
      c  = {c[DATA_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
    return c;
  endfunction

  // Handshake qualifiers and ready outputs; len_ready is held low until the
  // first clock after reset so reset values of all outputs are zero.
  always_comb begin
    w_slot_free = !r_d_valid || d_ready;
    len_ready   = r_started && (r_state == S_IDLE) && !r_cnt_valid;
    in_ready    = (r_state == S_PAYLOAD) && w_slot_free;
    w_len_acc   = len_valid && len_ready;
    w_in_acc    = in_valid && in_ready;
    w_trl_load  = (r_state == S_TRAILER) && w_slot_free;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_len_acc) begin
          w_state_nxt = (len_data != '0) ? S_PAYLOAD : S_TRAILER;
        end
      end
      S_PAYLOAD: begin
        if (w_in_acc && (r_remaining == DATA_W'(1))) begin
          w_state_nxt = S_TRAILER;
        end
      end
      S_TRAILER: begin
        if (w_slot_free) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register and post-reset start flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_started <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_started <= 1'b1;
    end
  end

  // Count channel register: loads on length accept, clears on its own handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_valid <= 1'b0;
      r_cnt_data  <= '0;
    end else if (w_len_acc) begin
      r_cnt_valid <= 1'b1;
      r_cnt_data  <= len_data;
    end else if (r_cnt_valid && cnt_ready) begin
      r_cnt_valid <= 1'b0;
    end
  end

  // One-entry data register: payload byte or trailer, only when the slot is free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d_valid <= 1'b0;
      r_d_data  <= '0;
    end else if (w_in_acc) begin
      r_d_valid <= 1'b1;
      r_d_data  <= in_data;
    end else if (w_trl_load) begin
      r_d_valid <= 1'b1;
      r_d_data  <= r_crc;
    end else if (r_d_valid && d_ready) begin
      r_d_valid <= 1'b0;
    end
  end

  // Running CRC and payload countdown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crc       <= CRC_INIT;
      r_remaining <= '0;
    end else if (w_len_acc) begin
      r_crc       <= CRC_INIT;
      r_remaining <= len_data;
    end else if (w_in_acc) begin
      r_crc       <= crc_next(r_crc, in_data);
      r_remaining <= r_remaining - DATA_W'(1);
    end
  end

  assign cnt_valid = r_cnt_valid;
  assign cnt_data  = r_cnt_data;
  assign d_valid   = r_d_valid;
  assign d_data    = r_d_data;
  assign busy      = (r_state == S_PAYLOAD) || (r_state == S_TRAILER);

endmodule
